// File: rtl/poly_horner_eval_pkg.sv
// rtl/poly_horner_eval_pkg.sv - shared state encodings and overflow mode constants
package poly_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/poly_horner_eval_if.sv
// rtl/poly_horner_eval_if.sv - start/finished handshake and operand/result bundle
interface poly_horner_eval_if #(
  parameter int DEGREE = 2,
  parameter int W      = 16,
  parameter int XW     = 8
);

  logic                        Start;
  logic signed [XW-1:0]        X;
  logic [(DEGREE+1)*W-1:0]     Coef;
  logic                        busy;
  logic                        finished;
  logic signed [W-1:0]         Resultado;
  logic                        Overflow;

  modport master (
    output Start, X, Coef,
    input  busy, finished, Resultado, Overflow
  );

  modport slave (
    input  Start, X, Coef,
    output busy, finished, Resultado, Overflow
  );

endinterface

// File: rtl/poly_horner_eval_mac_step.sv
// rtl/poly_horner_eval_mac_step.sv - one Horner step acc*x + c with range check
module poly_mac_step
  import poly_pkg::*;
#(
  parameter int W        = 16,
  parameter int XW       = 8,
  parameter int SATURATE = 0
) (
  input  logic signed [W-1:0]  acc,
  input  logic signed [XW-1:0] x,
  input  logic signed [W-1:0]  c,
  output logic signed [W-1:0]  next_acc,
  output logic                 ovf
);

  localparam int FW = W + XW + 1;

  logic signed [FW-1:0] acc_ext;
  logic signed [FW-1:0] x_ext;
  logic signed [FW-1:0] c_ext;
  logic signed [FW-1:0] full;

  assign acc_ext = {{(XW+1){acc[W-1]}}, acc};
  assign x_ext   = {{(W+1){x[XW-1]}}, x};
  assign c_ext   = {{(XW+1){c[W-1]}}, c};
  assign full    = acc_ext * x_ext + c_ext;

  // In range exactly when every bit above the W-bit sign position matches it.
  assign ovf = !((&full[FW-1:W-1]) || !(|full[FW-1:W-1]));

  always_comb begin
    next_acc = full[W-1:0];
    if (SATURATE == MODE_SAT && ovf) begin
      next_acc = full[FW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - sequential Horner polynomial evaluator, one MAC per clock
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int DEGREE   = 2,
  parameter int W        = 16,
  parameter int XW       = 8,
  parameter int SATURATE = 0
) (
  input logic               clk,
  input logic               Reset,
  poly_horner_eval_if.slave bus
);

  localparam int IW = $clog2(DEGREE) + 1;

  state_t                  state;
  state_t                  state_nx;
  logic                    accept;
  logic signed [XW-1:0]    x_reg;
  logic [DEGREE*W-1:0]     coef_reg;
  logic signed [W-1:0]     acc;
  logic [IW-1:0]           idx;
  logic                    ovf_run;
  logic signed [W-1:0]     c_sel;
  logic signed [W-1:0]     step_acc;
  logic                    step_ovf;

  // c_N seeds the accumulator at accept, so only c_0..c_(N-1) are kept.
  assign c_sel = coef_reg[int'(idx)*W +: W];

  poly_mac_step #(
    .W        (W),
    .XW       (XW),
    .SATURATE (SATURATE)
  ) u_mac (
    .acc      (acc),
    .x        (x_reg),
    .c        (c_sel),
    .next_acc (step_acc),
    .ovf      (step_ovf)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    bus.busy     = 1'b0;
    bus.finished = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        if (idx == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        bus.finished = 1'b1;
        if (bus.Start) begin
          accept   = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Overflow is accumulated internally and published only with the result.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      x_reg         <= '0;
      coef_reg      <= '0;
      acc           <= '0;
      idx           <= '0;
      ovf_run       <= 1'b0;
      bus.Resultado <= '0;
      bus.Overflow  <= 1'b0;
    end else if (accept) begin
      x_reg        <= bus.X;
      coef_reg     <= bus.Coef[DEGREE*W-1:0];
      acc          <= bus.Coef[DEGREE*W +: W];
      idx          <= IW'(DEGREE - 1);
      ovf_run      <= 1'b0;
      bus.Overflow <= 1'b0;
    end else if (state == ST_RUN) begin
      acc     <= step_acc;
      ovf_run <= ovf_run | step_ovf;
      if (idx == '0) begin
        bus.Resultado <= step_acc;
        bus.Overflow  <= ovf_run | step_ovf;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// tb/tb_poly_horner_eval.sv - directed self-checking bench for poly_horner_eval
module tb_poly_horner_eval;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  poly_horner_eval_if #(.DEGREE(2), .W(16), .XW(8)) ifw ();
  poly_horner_eval_if #(.DEGREE(2), .W(16), .XW(8)) ifs ();
  poly_horner_eval_if #(.DEGREE(3), .W(16), .XW(8)) if3w ();
  poly_horner_eval_if #(.DEGREE(3), .W(16), .XW(8)) if3s ();

  poly_horner_eval #(.DEGREE(2), .W(16), .XW(8), .SATURATE(0)) dut_w  (.clk(clk), .Reset(Reset), .bus(ifw));
  poly_horner_eval #(.DEGREE(2), .W(16), .XW(8), .SATURATE(1)) dut_s  (.clk(clk), .Reset(Reset), .bus(ifs));
  poly_horner_eval #(.DEGREE(3), .W(16), .XW(8), .SATURATE(0)) dut_3w (.clk(clk), .Reset(Reset), .bus(if3w));
  poly_horner_eval #(.DEGREE(3), .W(16), .XW(8), .SATURATE(1)) dut_3s (.clk(clk), .Reset(Reset), .bus(if3s));

  logic signed [15:0] m_acc, m_c, m_wrap_out, m_sat_out;
  logic signed [7:0]  m_x;
  logic               m_wrap_ovf, m_sat_ovf;

  poly_mac_step #(.W(16), .XW(8), .SATURATE(0)) mac_w (.acc(m_acc), .x(m_x), .c(m_c), .next_acc(m_wrap_out), .ovf(m_wrap_ovf));
  poly_mac_step #(.W(16), .XW(8), .SATURATE(1)) mac_s (.acc(m_acc), .x(m_x), .c(m_c), .next_acc(m_sat_out), .ovf(m_sat_ovf));

  localparam logic [47:0] COEF_A = {16'sd3, 16'sd4, 16'sd5};
  localparam logic [47:0] COEF_B = {16'sd4, 16'sd5, 16'sd32767};
  localparam logic [63:0] COEF_C = {16'sd1, 16'sd0, 16'sd0, 16'sd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_mac_step;
    m_acc = -16'sd56; m_x = -8'sd20; m_c = 16'sd5; #1;
    total++; if (m_wrap_out !== 16'sd1125 || m_wrap_ovf !== 1'b0) begin bad++; $display("FAIL mac_inrange: got %0d/%0b want 1125/0", m_wrap_out, m_wrap_ovf); end
    m_acc = 16'sd29; m_x = 8'sd6; m_c = 16'sd32767; #1;
    total++; if (m_wrap_out !== -16'sd32595 || m_wrap_ovf !== 1'b1) begin bad++; $display("FAIL mac_pos_wrap: got %0d/%0b want -32595/1", m_wrap_out, m_wrap_ovf); end
    total++; if (m_sat_out !== 16'sd32767 || m_sat_ovf !== 1'b1) begin bad++; $display("FAIL mac_pos_sat: got %0d/%0b want 32767/1", m_sat_out, m_sat_ovf); end
    m_acc = -16'sd32768; m_x = 8'sd2; m_c = 16'sd0; #1;
    total++; if (m_wrap_out !== 16'sd0 || m_wrap_ovf !== 1'b1) begin bad++; $display("FAIL mac_neg_wrap: got %0d/%0b want 0/1", m_wrap_out, m_wrap_ovf); end
    total++; if (m_sat_out !== -16'sd32768 || m_sat_ovf !== 1'b1) begin bad++; $display("FAIL mac_neg_sat: got %0d/%0b want -32768/1", m_sat_out, m_sat_ovf); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({ifw.busy, ifs.busy, if3w.busy, if3s.busy} !== 4'b0) begin bad++; $display("FAIL reset_busy: got %b want 0000", {ifw.busy, ifs.busy, if3w.busy, if3s.busy}); end
    total++; if ({ifw.finished, ifs.finished, if3w.finished, if3s.finished} !== 4'b0) begin bad++; $display("FAIL reset_finished: got %b want 0000", {ifw.finished, ifs.finished, if3w.finished, if3s.finished}); end
    total++; if ({ifw.Resultado, ifs.Resultado, if3w.Resultado, if3s.Resultado} !== 64'd0) begin bad++; $display("FAIL reset_resultado: got %h want 0", {ifw.Resultado, ifs.Resultado, if3w.Resultado, if3s.Resultado}); end
    total++; if ({ifw.Overflow, ifs.Overflow, if3w.Overflow, if3s.Overflow} !== 4'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0000", {ifw.Overflow, ifs.Overflow, if3w.Overflow, if3s.Overflow}); end
    @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    @(negedge clk);
    ifw.X = -8'sd20; ifw.Coef = COEF_A; ifw.Start = 1'b1;
    @(posedge clk); #1;
    ifw.Start = 1'b0;
    total++; if (ifw.busy !== 1'b1 || ifw.finished !== 1'b0) begin bad++; $display("FAIL basic_busy: got busy=%b fin=%b want 1/0", ifw.busy, ifw.finished); end
    n = 0;
    while (ifw.finished !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++; if (n != 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", n); end
    total++; if (ifw.Resultado !== 16'sd1125 || ifw.Overflow !== 1'b0) begin bad++; $display("FAIL basic_result: got %0d/%0b want 1125/0", ifw.Resultado, ifw.Overflow); end
    total++; if (ifw.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done: got %b want 0", ifw.busy); end
    @(posedge clk); #1;
    total++; if (ifw.finished !== 1'b0 || ifw.Resultado !== 16'sd1125) begin bad++; $display("FAIL basic_pulse: got fin=%b res=%0d want 0/1125", ifw.finished, ifw.Resultado); end
  endtask

  task automatic test_overflow;
    int n;
    @(negedge clk);
    ifw.X = 8'sd6; ifw.Coef = COEF_B; ifw.Start = 1'b1;
    ifs.X = 8'sd6; ifs.Coef = COEF_B; ifs.Start = 1'b1;
    @(posedge clk); #1;
    ifw.Start = 1'b0; ifs.Start = 1'b0;
    n = 0;
    while (ifw.finished !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++; if (n != 2 || ifs.finished !== 1'b1) begin bad++; $display("FAIL ovf_latency: got %0d sat_fin=%b want 2/1", n, ifs.finished); end
    total++; if (ifw.Resultado !== -16'sd32595 || ifw.Overflow !== 1'b1) begin bad++; $display("FAIL ovf_wrap: got %0d/%0b want -32595/1", ifw.Resultado, ifw.Overflow); end
    total++; if (ifs.Resultado !== 16'sd32767 || ifs.Overflow !== 1'b1) begin bad++; $display("FAIL ovf_sat: got %0d/%0b want 32767/1", ifs.Resultado, ifs.Overflow); end
    @(posedge clk);
  endtask

  task automatic test_degree3(input logic signed [7:0] xv, input logic signed [15:0] exp_w,
                              input logic signed [15:0] exp_s, input logic exp_ovf);
    int n;
    @(negedge clk);
    if3w.X = xv; if3w.Coef = COEF_C; if3w.Start = 1'b1;
    if3s.X = xv; if3s.Coef = COEF_C; if3s.Start = 1'b1;
    @(posedge clk); #1;
    if3w.Start = 1'b0; if3s.Start = 1'b0;
    n = 0;
    while (if3w.finished !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++; if (n != 3) begin bad++; $display("FAIL d3_latency x=%0d: got %0d want 3", xv, n); end
    total++; if (if3w.Resultado !== exp_w || if3w.Overflow !== exp_ovf) begin bad++; $display("FAIL d3_wrap x=%0d: got %0d/%0b want %0d/%0b", xv, if3w.Resultado, if3w.Overflow, exp_w, exp_ovf); end
    total++; if (if3s.Resultado !== exp_s || if3s.Overflow !== exp_ovf) begin bad++; $display("FAIL d3_sat x=%0d: got %0d/%0b want %0d/%0b", xv, if3s.Resultado, if3s.Overflow, exp_s, exp_ovf); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic exp_fin;
    total++; if (ifw.Overflow !== 1'b1) begin bad++; $display("FAIL b2b_pre_ovf: got %b want 1", ifw.Overflow); end
    @(negedge clk);
    ifw.X = -8'sd20; ifw.Coef = COEF_A; ifw.Start = 1'b1;
    @(posedge clk); #1;
    total++; if (ifw.Overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_clear: got %b want 0", ifw.Overflow); end
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      exp_fin = ((i % 3) == 2);
      total++; if (ifw.finished !== exp_fin) begin bad++; $display("FAIL b2b_finished cycle %0d: got %b want %b", i, ifw.finished, exp_fin); end
      if (exp_fin) begin
        total++; if (ifw.Resultado !== 16'sd1125) begin bad++; $display("FAIL b2b_result cycle %0d: got %0d want 1125", i, ifw.Resultado); end
      end
    end
    ifw.Start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_start_during_run;
    int pulses;
    @(negedge clk);
    ifw.X = -8'sd20; ifw.Coef = COEF_A; ifw.Start = 1'b1;
    @(posedge clk); #1;
    ifw.Start = 1'b0;
    @(posedge clk); #1;
    ifw.Start = 1'b1; ifw.X = 8'sd6; ifw.Coef = COEF_B;
    @(posedge clk); #1;
    ifw.Start = 1'b0;
    pulses = 0;
    if (ifw.finished === 1'b1) begin
      pulses++;
      total++; if (ifw.Resultado !== 16'sd1125 || ifw.Overflow !== 1'b0) begin bad++; $display("FAIL ignore_result: got %0d/%0b want 1125/0", ifw.Resultado, ifw.Overflow); end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ifw.finished === 1'b1) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
    total++; if (ifw.busy !== 1'b0) begin bad++; $display("FAIL ignore_idle: got busy=%b want 0", ifw.busy); end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    int n;
    @(negedge clk);
    ifw.X = 8'sd6; ifw.Coef = COEF_B; ifw.Start = 1'b1;
    @(posedge clk); #1;
    ifw.Start = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    #1;
    total++; if (ifw.busy !== 1'b0 || ifw.finished !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: got busy=%b fin=%b want 0/0", ifw.busy, ifw.finished); end
    total++; if (ifw.Resultado !== 16'sd0 || ifw.Overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_out: got %0d/%0b want 0/0", ifw.Resultado, ifw.Overflow); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ifw.finished === 1'b1) pulses++;
    end
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (ifw.finished === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_pulse: got %0d want 0", pulses); end
    @(negedge clk);
    ifw.X = -8'sd20; ifw.Coef = COEF_A; ifw.Start = 1'b1;
    @(posedge clk); #1;
    ifw.Start = 1'b0;
    n = 0;
    while (ifw.finished !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++; if (n != 2 || ifw.Resultado !== 16'sd1125 || ifw.Overflow !== 1'b0) begin bad++; $display("FAIL rst_fresh: got lat=%0d res=%0d ovf=%b want 2/1125/0", n, ifw.Resultado, ifw.Overflow); end
  endtask

  initial begin
    ifw.Start = 1'b0;  ifw.X = '0;  ifw.Coef = '0;
    ifs.Start = 1'b0;  ifs.X = '0;  ifs.Coef = '0;
    if3w.Start = 1'b0; if3w.X = '0; if3w.Coef = '0;
    if3s.Start = 1'b0; if3s.X = '0; if3s.Coef = '0;
    m_acc = '0; m_x = '0; m_c = '0;
    test_mac_step();
    test_reset();
    test_basic();
    test_overflow();
    test_degree3(-8'sd32, -16'sd32768, -16'sd32768, 1'b0);
    test_degree3(8'sd32, -16'sd32768, 16'sd32767, 1'b1);
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_horner_eval.md
# poly_horner_eval

Parametrised sequential polynomial evaluator computing p(X) = c_N·X^N + … + c_1·X + c_0 with Horner's rule, one multiply-accumulate per clock. It generalises the fixed second-order A·X²+B·X+C control/datapath pair to arbitrary degree, operand widths and overflow mode (wrap or saturate). It keeps the start/finished handshake and the overflow flag, and adds a busy output and a back-to-back restart capability. It sits as a leaf compute unit beside the existing control/datapath blocks.

## Interface
- DEGREE, 2: polynomial order N; legal range ≥ 1.
- W, 16: signed width of coefficients, accumulator and Resultado.
- XW, 8: signed width of X.
- SATURATE, 0: 0 = two's-complement wrap on overflow; 1 = clamp to the signed W-bit max/min.
- clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- X  in  XW  signed evaluation point; captured on the accepted Start edge.
- Coef  in  (DEGREE+1)·W  packed signed coefficients; slice [i·W +: W] = c_i, so c_0 occupies the LSBs; captured on the accepted Start edge.
- busy  out  1  operation in flight (RUN state).
- finished  out  1  one-cycle pulse; Resultado/Overflow valid.
- Resultado  out  W  signed result; held until the next accepted Start.
- Overflow  out  1  sticky per operation; held with Resultado.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE; busy=0, finished=0, Resultado=0, Overflow=0, acc=0, index=0.
- Accept (IDLE or DONE, Start=1):
  - capture X and Coef;
  - acc ← c_N; index ← DEGREE−1; Overflow ← 0;
  - go to RUN.
- RUN, each edge:
  - full = acc·X + sext(c_index), computed at W+XW+1 bits signed;
  - step overflow when full ∉ [−2^(W−1), 2^(W−1)−1];
  - acc ← full[W−1:0] (wrap), or the clamped value (SATURATE=1);
  - Overflow |= step overflow;
  - when index=0: Resultado ← new acc, finished ← 1, go to DONE; otherwise index−1.
- DONE, one cycle: finished=1. Start=1 restarts as in Accept; otherwise go to IDLE.
- Start in RUN is ignored; no queueing.
- Overflow is sticky: a later step that returns into range does not clear it.
- Saturation is applied per step. The accumulator continues from the clamped value.
- Reset asserted mid-RUN abandons the operation immediately: no finished pulse, and all outputs return to their reset values.

## Timing
- Accept edge = edge 0. RUN edges are 1…DEGREE.
- finished is high in the cycle following edge DEGREE. Latency from the Start edge to finished = DEGREE cycles.
- busy is high from edge 0 until edge DEGREE (DEGREE cycles).
- Minimum Start-to-Start period: DEGREE+1 cycles, achieved by restarting from DONE.
- Resultado and Overflow change only at the finishing edge, the accept edge (Overflow clears) and reset.
- Reset is asynchronous on assertion. Deassertion must be synchronised externally to clk.

## Structure
- Package poly_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants MODE_WRAP=0, MODE_SAT=1.
- Sub-module poly_mac_step, purely combinational:
  - parameters W, XW, SATURATE;
  - inputs acc, x, c;
  - outputs next_acc, ovf.
  - It isolates the extended-width multiply-add and range check so the bench can test it standalone.
- Top level holds only the FSM, the down-counter ($clog2(DEGREE)+1 bits), operand registers and output registers.

## Test plan
- Defaults, X=−20, c2=3, c1=4, c0=5, Start one cycle → finished 2 cycles after the Start edge; Resultado=1125, Overflow=0.
- Defaults, X=6, c2=4, c1=5, c0=32767:
  - SATURATE=0 → Resultado=−32595, Overflow=1;
  - SATURATE=1 → Resultado=32767, Overflow=1.
- DEGREE=3, c3=1, others 0:
  - X=−32 → Resultado=−32768, Overflow=0 (exact boundary);
  - X=32 → wrap gives −32768, sat gives 32767, Overflow=1 in both.
- Start held high continuously, default operands → finished pulses every 3 cycles. Overflow from the previous op clears on re-accept.
- Start pulsed again during RUN → ignored; exactly one finished pulse with the original result.
- Reset low at RUN edge 1 → busy/finished/Resultado/Overflow = 0 immediately (asynchronous); no finished pulse; a fresh Start after release evaluates correctly.
